// File: rtl/jelly_img_gamma_table_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : jelly_img_gamma_table_loader
// Purpose  : Double-buffered gamma LUT loader; stream/fill writes go to the
//            shadow bank, banks swap only on a qualified frame start.
// Revision : 1.0 - initial release
// ============================================================================
module jelly_img_gamma_table_loader #(
    parameter int S_DATA_WIDTH  = 8,
    parameter int M_DATA_WIDTH  = 8,
    parameter int INIT_IDENTITY = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    cke,
    input  logic                    frame_start,
    input  logic                    s_wr_valid,
    output logic                    s_wr_ready,
    input  logic [S_DATA_WIDTH-1:0] s_wr_addr,
    input  logic [M_DATA_WIDTH-1:0] s_wr_data,
    input  logic                    s_init,
    input  logic                    s_update_req,
    output logic                    mem_en,
    output logic [S_DATA_WIDTH:0]   mem_addr,
    output logic [M_DATA_WIDTH-1:0] mem_din,
    output logic                    active_bank,
    output logic                    update_pending,
    output logic                    update_ack,
    output logic                    busy
);

    localparam int S = S_DATA_WIDTH;
    localparam int M = M_DATA_WIDTH;

    localparam logic [S+1:0] c_ALL_WORDS  = {1'b1, {(S+1){1'b0}}};
    localparam logic [S+1:0] c_BANK_WORDS = {2'b01, {S{1'b0}}};
    localparam logic [S+1:0] c_CNT_ONE    = {{(S+1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_FILL = 2'd2
    } state_t;

    state_t          r_state;
    logic [S+1:0]    r_cnt;
    logic            r_run;
    logic            r_mem_en;
    logic [S:0]      r_mem_addr;
    logic [M-1:0]    r_mem_din;
    logic            r_active_bank;
    logic            r_update_pending;
    logic            r_update_ack;

    logic            w_idle;
    logic            w_shadow;
    logic            w_wr_ready;
    logic            w_wr_accept;
    logic            w_init_ok;
    logic            w_swap;

    // Expand an S-bit index to M bits: truncate, or left-align and refill
    // the low bits with the index MSBs (one copy, zeros beyond that).
    function automatic logic [M-1:0] identity(input logic [S-1:0] a);
        logic [M-1:0] v;
        v = '0;
        for (int j = 0; j < M; j++) begin
            if (j < S)
                v[M-1-j] = a[S-1-j];
            else if (j < 2*S)
                v[M-1-j] = a[2*S-1-j];
        end
        return v;
    endfunction

    assign w_idle      = (r_state == ST_IDLE);
    assign w_shadow    = ~r_active_bank;
    assign w_wr_ready  = r_run & w_idle & ~r_update_pending;
    assign w_wr_accept = s_wr_valid & w_wr_ready;
    assign w_init_ok   = s_init & w_wr_ready;
    assign w_swap      = r_update_pending & w_idle & cke & frame_start;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state          <= (INIT_IDENTITY != 0) ? ST_INIT : ST_IDLE;
            r_cnt            <= '0;
            r_run            <= 1'b0;
            r_mem_en         <= 1'b0;
            r_mem_addr       <= '0;
            r_mem_din        <= '0;
            r_active_bank    <= 1'b0;
            r_update_pending <= 1'b0;
            r_update_ack     <= 1'b0;
        end else begin
            r_run        <= 1'b1;
            r_mem_en     <= 1'b0;
            r_update_ack <= 1'b0;

            // A request in the swap cycle itself is a fresh request.
            if (w_swap) begin
                r_active_bank    <= ~r_active_bank;
                r_update_ack     <= 1'b1;
                r_update_pending <= s_update_req;
            end else if (s_update_req) begin
                r_update_pending <= 1'b1;
            end

            case (r_state)
                ST_INIT: begin
                    if (r_cnt == c_ALL_WORDS) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_mem_en   <= 1'b1;
                        r_mem_addr <= r_cnt[S:0];
                        r_mem_din  <= identity(r_cnt[S-1:0]);
                        r_cnt      <= r_cnt + c_CNT_ONE;
                    end
                end
                ST_IDLE: begin
                    if (w_wr_accept) begin
                        r_mem_en   <= 1'b1;
                        r_mem_addr <= {w_shadow, s_wr_addr};
                        r_mem_din  <= s_wr_data;
                    end
                    if (w_init_ok) begin
                        r_state <= ST_FILL;
                        // A coinciding stream beat owns this write slot.
                        if (w_wr_accept) begin
                            r_cnt <= '0;
                        end else begin
                            r_mem_en   <= 1'b1;
                            r_mem_addr <= {w_shadow, {S{1'b0}}};
                            r_mem_din  <= identity({S{1'b0}});
                            r_cnt      <= c_CNT_ONE;
                        end
                    end
                end
                ST_FILL: begin
                    if (r_cnt == c_BANK_WORDS) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_mem_en   <= 1'b1;
                        r_mem_addr <= {w_shadow, r_cnt[S-1:0]};
                        r_mem_din  <= identity(r_cnt[S-1:0]);
                        r_cnt      <= r_cnt + c_CNT_ONE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign s_wr_ready     = w_wr_ready;
    assign mem_en         = r_mem_en;
    assign mem_addr       = r_mem_addr;
    assign mem_din        = r_mem_din;
    assign active_bank    = r_active_bank;
    assign update_pending = r_update_pending;
    assign update_ack     = r_update_ack;
    assign busy           = ~w_idle;

endmodule
`default_nettype wire
